// File: rtl/hs_arb_mux_pkg.sv
// Shared types and helpers for the arbitrating handshake multiplexer.
package hs_arb_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int MAX_N = 32;

    function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hs_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
interface hs_arb_mux_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]       in_valid_i;
    logic [N*WIDTH-1:0] in_data_i;
    logic [N-1:0]       in_ready_o;
    logic               out_valid_o;
    logic [WIDTH-1:0]   out_data_o;
    logic [N-1:0]       out_grant_o;
    logic               out_ready_i;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_grant_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_grant_o
    );
endinterface

// File: rtl/hs_arb_mux_rr_pick.sv
// Combinational one-hot picker: lowest request at or above ptr, wrapping,
// built as a priority encoder over {req, req masked below ptr}.
module rr_pick
    import hs_arb_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N-1:0]     gnt
);
    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    logic           w_seen;

    // Mask out channels below the pointer; fixed mode searches from index 0.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (mode == ARB_RR) ? (i >= int'(ptr)) : 1'b1;
        end
        w_dbl = {req, req & w_mask};
    end

    // First set bit of the doubled vector, folded back onto N channels.
    always_comb begin
        gnt    = '0;
        w_seen = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            gnt[i % N] = gnt[i % N] | (w_dbl[i] & ~w_seen);
            w_seen     = w_seen | w_dbl[i];
        end
    end
endmodule

// File: rtl/hs_arb_mux.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority
// arbitration into a single registered output stage.
module hs_arb_mux
    import hs_arb_mux_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    hs_arb_mux_if.slave   bus
);
    localparam int        PTR_W = $clog2(N);
    localparam arb_mode_e MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [N-1:0]     r_out_grant;
    logic [N-1:0]     w_grant;
    logic [WIDTH-1:0] w_win_data;
    logic [MAX_N-1:0] w_grant_ext;
    logic             w_load_en;
    logic             w_any_req;
    int               w_win_idx;

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req  (bus.in_valid_i),
        .ptr  (r_ptr),
        .mode (MODE),
        .gnt  (w_grant)
    );

    assign w_load_en = ~r_out_valid | bus.out_ready_i;
    assign w_any_req = |bus.in_valid_i;

    // Reset also gates ready so no producer sees an accept while held in reset.
    assign bus.in_ready_o  = w_grant & {N{w_load_en & reset_n}};
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_grant_o = r_out_grant;

    // AND-OR mux of the winning channel's data.
    always_comb begin
        w_win_data = '0;
        for (int k = 0; k < N; k++) begin
            w_win_data = w_win_data | (bus.in_data_i[k*WIDTH +: WIDTH] & {WIDTH{w_grant[k]}});
        end
    end

    // Next pointer: one past the winner, with explicit wrap for any N.
    always_comb begin
        w_grant_ext          = '0;
        w_grant_ext[N-1:0]   = w_grant;
        w_win_idx            = onehot_to_idx(w_grant_ext);
        if (w_win_idx == N - 1) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = PTR_W'(w_win_idx + 1);
        end
    end

    // Output register and priority pointer; everything holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_grant <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_any_req) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_win_data;
                r_out_grant <= w_grant;
                if (MODE == ARB_RR) begin
                    r_ptr <= w_ptr_nxt;
                end else begin
                    r_ptr <= '0;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hs_arb_mux.sv
// Self-checking bench: directed vector table, reset/fixed-mode sequences,
// and randomized traffic against a behavioural arbitration model.
module tb_hs_arb_mux;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    hs_arb_mux_if #(.N(4), .WIDTH(8)) bus ();
    hs_arb_mux_if #(.N(4), .WIDTH(8)) bus_f ();

    hs_arb_mux #(.N(4), .WIDTH(8), .RR_MODE(1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    hs_arb_mux #(.N(4), .WIDTH(8), .RR_MODE(0)) u_dut_fixed (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_f)
    );

    assign bus_f.in_valid_i  = bus.in_valid_i;
    assign bus_f.in_data_i   = bus.in_data_i;
    assign bus_f.out_ready_i = bus.out_ready_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  e_inrdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic [3:0]  e_gnt;
    } vec_t;

    vec_t tbl [16];

    // behavioural model state
    int          m_ptr;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [3:0]  m_grant;
    logic        f_valid;
    logic [7:0]  f_data;
    logic [3:0]  f_grant;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic r);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
    endtask

    initial begin
        logic [3:0]  v;
        logic [31:0] d;
        logic        r;
        int          w;
        int          fw;
        logic        m_load;
        logic        f_load;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_frdy;

        total = 0;
        bad   = 0;
        reset_n = 1'b1;
        apply(4'b0000, 32'h0, 1'b1);

        tbl[0]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
        tbl[1]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 4'b0010};
        tbl[2]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0100};
        tbl[3]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA3, 4'b1000};
        tbl[4]  = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
        tbl[5]  = '{4'b0100, 32'h005C0000, 1'b1, 4'b0100, 1'b1, 8'h5C, 4'b0100};
        tbl[6]  = '{4'b1010, 32'hB300B100, 1'b0, 4'b0000, 1'b1, 8'h5C, 4'b0100};
        tbl[7]  = '{4'b1010, 32'hB300B100, 1'b0, 4'b0000, 1'b1, 8'h5C, 4'b0100};
        tbl[8]  = '{4'b1010, 32'hB300B100, 1'b0, 4'b0000, 1'b1, 8'h5C, 4'b0100};
        tbl[9]  = '{4'b1010, 32'hB300B100, 1'b1, 4'b1000, 1'b1, 8'hB3, 4'b1000};
        tbl[10] = '{4'b1000, 32'h33000000, 1'b1, 4'b1000, 1'b1, 8'h33, 4'b1000};
        tbl[11] = '{4'b0001, 32'h00000011, 1'b1, 4'b0001, 1'b1, 8'h11, 4'b0001};
        tbl[12] = '{4'b0010, 32'h00007E00, 1'b1, 4'b0010, 1'b1, 8'h7E, 4'b0010};
        tbl[13] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h7E, 4'b0010};
        tbl[14] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h7E, 4'b0010};
        tbl[15] = '{4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0100};

        // power-on reset
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst_data",  32'(bus.out_data_o),  32'h0);
        chk("rst_grant", 32'(bus.out_grant_o), 32'h0);
        reset_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].valid, tbl[i].data, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready_o), 32'(tbl[i].e_inrdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid_o), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_data", i),  32'(bus.out_data_o),  32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_grant", i), 32'(bus.out_grant_o), 32'(tbl[i].e_gnt));
        end

        // asynchronous reset mid-stream with out_valid_o high
        reset_n = 1'b0;
        #1;
        chk("amid_valid",    32'(bus.out_valid_o), 32'h0);
        chk("amid_data",     32'(bus.out_data_o),  32'h0);
        chk("amid_grant",    32'(bus.out_grant_o), 32'h0);
        chk("amid_in_ready", 32'(bus.in_ready_o),  32'h0);
        chk("amid_f_ready",  32'(bus_f.in_ready_o), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(4'b1111, 32'hA3A2A1A0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'(4'b0001 << i));
            @(posedge clk);
            #1;
            chk("post_rst_grant", 32'(bus.out_grant_o), 32'(4'b0001 << i));
            chk("post_rst_data",  32'(bus.out_data_o),  32'(8'hA0 + 8'(i)));
        end

        // fixed priority: ch0 always wins while everyone requests
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fixed_in_ready", 32'(bus_f.in_ready_o), 32'h1);
            @(posedge clk);
            #1;
            chk("fixed_valid", 32'(bus_f.out_valid_o), 32'h1);
            chk("fixed_grant", 32'(bus_f.out_grant_o), 32'h1);
            chk("fixed_data",  32'(bus_f.out_data_o),  32'hA0);
        end

        // randomized traffic vs. model
        reset_n = 1'b0;
        apply(4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_grant = 4'b0000;
        f_valid = 1'b0; f_data = 8'h00; f_grant = 4'b0000;
        v = 4'($urandom_range(0, 15));
        d = $urandom;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = ($urandom_range(0, 3) != 0);
            apply(v, d, r);

            w = -1;
            for (int off = 0; off < 4; off++) begin
                if (w < 0 && v[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
            end
            fw = -1;
            for (int k = 3; k >= 0; k--) begin
                if (v[k]) fw = k;
            end
            m_load   = !m_valid || r;
            f_load   = !f_valid || r;
            exp_rdy  = (m_load && w >= 0)  ? 4'(1 << w)  : 4'b0000;
            exp_frdy = (f_load && fw >= 0) ? 4'(1 << fw) : 4'b0000;

            @(negedge clk);
            chk("rnd_in_ready",   32'(bus.in_ready_o),   32'(exp_rdy));
            chk("rnd_f_in_ready", 32'(bus_f.in_ready_o), 32'(exp_frdy));
            @(posedge clk);
            #1;

            if (m_load) begin
                if (w >= 0) begin
                    m_valid = 1'b1;
                    m_data  = d[w*8 +: 8];
                    m_grant = 4'(1 << w);
                    m_ptr   = (w + 1) % 4;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (f_load) begin
                if (fw >= 0) begin
                    f_valid = 1'b1;
                    f_data  = d[fw*8 +: 8];
                    f_grant = 4'(1 << fw);
                end else begin
                    f_valid = 1'b0;
                end
            end

            chk("rnd_valid",   32'(bus.out_valid_o),   32'(m_valid));
            chk("rnd_f_valid", 32'(bus_f.out_valid_o), 32'(f_valid));
            if (m_valid) begin
                chk("rnd_data",  32'(bus.out_data_o),  32'(m_data));
                chk("rnd_grant", 32'(bus.out_grant_o), 32'(m_grant));
            end
            if (f_valid) begin
                chk("rnd_f_data",  32'(bus_f.out_data_o),  32'(f_data));
                chk("rnd_f_grant", 32'(bus_f.out_grant_o), 32'(f_grant));
            end

            // producers hold valid/data until accepted by the round-robin mux
            for (int k = 0; k < 4; k++) begin
                if (!(v[k] && !exp_rdy[k])) begin
                    v[k]         = ($urandom_range(0, 1) == 1);
                    d[k*8 +: 8]  = 8'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
